// File: rtl/assoc_cache_unit.sv
// assoc_cache_unit: N-way set-associative write-back/write-allocate data cache with per-set LRU.
// Define CACHE_STATS_EN to add saturating o_HitCount/o_MissCount outputs.
module assoc_cache_unit #(
    parameter int BUS_WIDTH       = 32,
    parameter int ADDRESS_WIDTH   = 10,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int INDEX_SIZE      = 3,
    parameter int WAYS            = 2
) (
    input  logic                                           i_clk,
    input  logic                                           i_aresetn,
    input  logic                                           i_MemRead,
    input  logic                                           i_MemWrite,
    input  logic [ADDRESS_WIDTH-1:0]                       i_AddressCpu,
    input  logic [BUS_WIDTH-1:0]                           i_data,
    output logic [BUS_WIDTH-1:0]                           o_DataToCpu,
    output logic                                           o_Hit_Or_Miss,
    output logic                                           o_stall,
    output logic                                           o_MemReq,
    output logic                                           o_MemWe,
    output logic [ADDRESS_WIDTH-$clog2(WORDS_PER_BLOCK)-1:0] o_MemAddress,
    output logic [BUS_WIDTH*WORDS_PER_BLOCK-1:0]           o_MemWData,
    input  logic                                           i_MemReady,
    input  logic [BUS_WIDTH*WORDS_PER_BLOCK-1:0]           i_MemRData
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]                                    o_HitCount,
    output logic [15:0]                                    o_MissCount
`endif
);
    localparam int OFFSET_SIZE = $clog2(WORDS_PER_BLOCK);
    localparam int TAG_SIZE    = ADDRESS_WIDTH - INDEX_SIZE - OFFSET_SIZE;
    localparam int SETS        = 2 ** INDEX_SIZE;
    localparam int LRU_BITS    = WAYS > 1 ? $clog2(WAYS) : 1;
    localparam int LINE_W      = BUS_WIDTH * WORDS_PER_BLOCK;
    localparam int BLOCK_W     = ADDRESS_WIDTH - OFFSET_SIZE;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

    state_t              state;
    logic [SETS-1:0]     valid [WAYS];
    logic [SETS-1:0]     dirty [WAYS];
    logic [TAG_SIZE-1:0] tags  [WAYS][SETS];
    logic [LINE_W-1:0]   lines [WAYS][SETS];
    logic [LRU_BITS-1:0] age   [WAYS][SETS];
    logic [BLOCK_W-1:0]  req_block;
    logic [LRU_BITS-1:0] victim, hit_way, pick, touch_way, old_age;
    logic [TAG_SIZE-1:0] tag;
    logic [INDEX_SIZE-1:0] index, req_index, set_index;
    logic [OFFSET_SIZE-1:0] offset;
    logic active, hit, idle_hit, miss, touch;

    assign tag       = i_AddressCpu[ADDRESS_WIDTH-1 -: TAG_SIZE];
    assign index     = i_AddressCpu[OFFSET_SIZE +: INDEX_SIZE];
    assign offset    = i_AddressCpu[OFFSET_SIZE-1:0];
    assign req_index = req_block[INDEX_SIZE-1:0];

    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        pick = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (age[w][index] == LRU_BITS'(WAYS - 1)) pick = LRU_BITS'(w);
        end
        // an invalid way always beats the LRU choice, lowest index first
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w][index]) pick = LRU_BITS'(w);
            if (valid[w][index] && tags[w][index] == tag) begin
                hit = 1'b1;
                hit_way = LRU_BITS'(w);
            end
        end
    end

    assign active    = (i_MemRead | i_MemWrite) & i_aresetn;
    assign idle_hit  = state == IDLE && active && hit;
    assign miss      = state == IDLE && active && !hit;
    assign touch     = idle_hit || (state == REFILL && i_MemReady);
    assign touch_way = state == IDLE ? hit_way : victim;
    assign set_index = state == IDLE ? index : req_index;
    // an invalid way is treated as oldest so every other way ages when it is filled
    assign old_age   = valid[touch_way][set_index] ? age[touch_way][set_index] : LRU_BITS'(WAYS - 1);

    assign o_Hit_Or_Miss = idle_hit;
    assign o_stall       = state != IDLE || miss;
    assign o_DataToCpu   = idle_hit && !i_MemWrite ? lines[hit_way][index][offset * BUS_WIDTH +: BUS_WIDTH] : '0;
    assign o_MemReq      = state != IDLE;
    assign o_MemWe       = state == WRITEBACK;
    assign o_MemAddress  = state == WRITEBACK ? {tags[victim][req_index], req_index} : req_block;
    assign o_MemWData    = lines[victim][req_index];

    always_ff @(posedge i_clk) begin
        if (!i_aresetn) begin
            state <= IDLE;
            for (int w = 0; w < WAYS; w++) begin
                valid[w] <= '0;
                dirty[w] <= '0;
                for (int s = 0; s < SETS; s++) age[w][s] <= '0;
            end
        end else begin
            if (touch) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (LRU_BITS'(w) == touch_way) age[w][set_index] <= '0;
                    else if (age[w][set_index] < old_age) age[w][set_index] <= age[w][set_index] + 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (idle_hit && i_MemWrite) begin
                        lines[hit_way][index][offset * BUS_WIDTH +: BUS_WIDTH] <= i_data;
                        dirty[hit_way][index] <= 1'b1;
                    end
                    if (miss) begin
                        victim <= pick;
                        req_block <= i_AddressCpu[ADDRESS_WIDTH-1:OFFSET_SIZE];
                        state <= valid[pick][index] && dirty[pick][index] ? WRITEBACK : REFILL;
                    end
                end
                WRITEBACK: begin
                    if (i_MemReady) begin
                        dirty[victim][req_index] <= 1'b0;
                        state <= REFILL;
                    end
                end
                REFILL: begin
                    if (i_MemReady) begin
                        lines[victim][req_index] <= i_MemRData;
                        tags[victim][req_index] <= req_block[BLOCK_W-1 -: TAG_SIZE];
                        valid[victim][req_index] <= 1'b1;
                        dirty[victim][req_index] <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic retry;
    logic [15:0] hit_cnt, miss_cnt;

    // the hit that retires a refilled request is not a fresh hit
    always_ff @(posedge i_clk) begin
        if (!i_aresetn) begin
            retry <= 1'b0;
            hit_cnt <= '0;
            miss_cnt <= '0;
        end else begin
            retry <= state == REFILL && i_MemReady;
            if (idle_hit && !retry && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 1'b1;
            if (miss && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 1'b1;
        end
    end

    assign o_HitCount  = hit_cnt;
    assign o_MissCount = miss_cnt;
`endif
endmodule

// File: tb/tb_assoc_cache_unit.sv
// tb_assoc_cache_unit: directed self-checking bench for assoc_cache_unit (default parameters).
module tb_assoc_cache_unit;
    localparam logic [127:0] LINE_A = {32'hA5A5_0004, 32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001};
    localparam logic [127:0] LINE_B = {32'hB0B0_0004, 32'hB0B0_0003, 32'hB0B0_0002, 32'hB0B0_0001};
    localparam logic [127:0] LINE_C = {32'hC0C0_0004, 32'hC0C0_0003, 32'hC0C0_0002, 32'hC0C0_0001};
    localparam logic [127:0] LINE_D = {32'hD0D0_0004, 32'hD0D0_0003, 32'hD0D0_0002, 32'hD0D0_0001};
    localparam logic [127:0] LINE_E = {32'hE0E0_0004, 32'hE0E0_0003, 32'hE0E0_0002, 32'hE0E0_0001};
    localparam logic [127:0] LINE_F = {32'hF0F0_0004, 32'hF0F0_0003, 32'hF0F0_0002, 32'hF0F0_0001};

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [9:0]   addr = '0;
    logic [31:0]  wdata = '0;
    logic [31:0]  rdata_cpu;
    logic         hit_miss;
    logic         stall;
    logic         mem_req;
    logic         mem_we;
    logic [6:0]   mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ready = 1'b0;
    logic [127:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
    logic [15:0]  hit_count, miss_count;
`endif

    int tests = 0;
    int errors = 0;
    int stalls, n_wb, n_rf;
    logic [31:0]  rd;
    logic         hm;
    logic [6:0]   wb_addr, rf_addr;
    logic [127:0] wb_data;

    always #5 clk = ~clk;

    assoc_cache_unit dut (
        .i_clk(clk),
        .i_aresetn(rstn),
        .i_MemRead(mem_read),
        .i_MemWrite(mem_write),
        .i_AddressCpu(addr),
        .i_data(wdata),
        .o_DataToCpu(rdata_cpu),
        .o_Hit_Or_Miss(hit_miss),
        .o_stall(stall),
        .o_MemReq(mem_req),
        .o_MemWe(mem_we),
        .o_MemAddress(mem_addr),
        .o_MemWData(mem_wdata),
        .i_MemReady(mem_ready),
        .i_MemRData(mem_rdata)
`ifdef CACHE_STATS_EN
        ,
        .o_HitCount(hit_count),
        .o_MissCount(miss_count)
`endif
    );

    // One CPU access with a memory model: ready comes lw/lr cycles after the request rises
    // or after the previous ready, so a miss stalls (dirty ? lw : 0) + lr + 2 cycles.
    task automatic access(input logic wr, input logic [9:0] a, input logic [31:0] wd,
                          input logic [127:0] line, input int lw, input int lr);
        int cnt;
        bit done;
        @(negedge clk);
        mem_read = !wr;
        mem_write = wr;
        addr = a;
        wdata = wd;
        mem_rdata = line;
        stalls = 0;
        n_wb = 0;
        n_rf = 0;
        cnt = 0;
        done = 0;
        for (int c = 0; c < 500 && !done; c++) begin
            #1;
            if (!stall) done = 1;
            else begin
                stalls++;
                if (mem_req) begin
                    if (mem_we) begin
                        wb_addr = mem_addr;
                        wb_data = mem_wdata;
                    end else rf_addr = mem_addr;
                    if (cnt == (mem_we ? lw : lr)) begin
                        mem_ready = 1'b1;
                        cnt = 1;
                        if (mem_we) n_wb++;
                        else n_rf++;
                    end else cnt++;
                end
                @(negedge clk);
                mem_ready = 1'b0;
            end
        end
        rd = rdata_cpu;
        hm = hit_miss;
        if (!done) begin
            tests++;
            errors++;
            $display("FAIL access_timeout addr=%h stall still high after %0d cycles (required low)", a, stalls);
        end
        @(negedge clk);
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        tests++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
        tests++; if (hit_miss !== 1'b0) begin errors++; $display("FAIL reset_hit got %b exp 0", hit_miss); end
        tests++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_memreq got %b exp 0", mem_req); end
        tests++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_memwe got %b exp 0", mem_we); end
        tests++; if (rdata_cpu !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", rdata_cpu); end
    endtask

    task automatic test_cold_load;
        access(1'b0, 10'h004, 32'h0, LINE_A, 1, 3);
        tests++; if (stalls !== 5) begin errors++; $display("FAIL cold_stall got %0d exp 5", stalls); end
        tests++; if (n_rf !== 1 || n_wb !== 0) begin errors++; $display("FAIL cold_txn got rf=%0d wb=%0d exp rf=1 wb=0", n_rf, n_wb); end
        tests++; if (rf_addr !== 7'h01) begin errors++; $display("FAIL cold_rfaddr got %h exp 01", rf_addr); end
        tests++; if (rd !== 32'hA5A5_0001) begin errors++; $display("FAIL cold_data got %h exp a5a50001", rd); end
        tests++; if (hm !== 1'b1) begin errors++; $display("FAIL cold_hit got %b exp 1", hm); end
    endtask

    task automatic test_store_hit;
        access(1'b1, 10'h004, 32'hDEAD_BEEF, LINE_A, 1, 1);
        tests++; if (stalls !== 0) begin errors++; $display("FAIL store_stall got %0d exp 0", stalls); end
        tests++; if (hm !== 1'b1) begin errors++; $display("FAIL store_hit got %b exp 1", hm); end
        tests++; if (rd !== 32'h0) begin errors++; $display("FAIL store_data got %h exp 0", rd); end
        access(1'b0, 10'h004, 32'h0, LINE_A, 1, 1);
        tests++; if (rd !== 32'hDEAD_BEEF || stalls !== 0) begin errors++; $display("FAIL store_readback got %h/%0d exp deadbeef/0", rd, stalls); end
        access(1'b0, 10'h006, 32'h0, LINE_A, 1, 1);
        tests++; if (rd !== 32'hA5A5_0003) begin errors++; $display("FAIL offset2_data got %h exp a5a50003", rd); end
    endtask

    task automatic test_lru;
        access(1'b0, 10'h024, 32'h0, LINE_B, 1, 2);
        tests++; if (stalls !== 4 || n_wb !== 0) begin errors++; $display("FAIL lru_fill1 got stall=%0d wb=%0d exp 4/0", stalls, n_wb); end
        tests++; if (rf_addr !== 7'h09 || rd !== 32'hB0B0_0001) begin errors++; $display("FAIL lru_fill1_data got %h/%h exp 09/b0b00001", rf_addr, rd); end
        access(1'b0, 10'h004, 32'h0, LINE_A, 1, 1);
        tests++; if (stalls !== 0) begin errors++; $display("FAIL lru_touch got %0d exp 0", stalls); end
        access(1'b0, 10'h044, 32'h0, LINE_C, 1, 1);
        tests++; if (stalls !== 3 || n_wb !== 0) begin errors++; $display("FAIL lru_evict got stall=%0d wb=%0d exp 3/0", stalls, n_wb); end
        tests++; if (rf_addr !== 7'h11 || rd !== 32'hC0C0_0001) begin errors++; $display("FAIL lru_evict_data got %h/%h exp 11/c0c00001", rf_addr, rd); end
        access(1'b0, 10'h004, 32'h0, LINE_A, 1, 1);
        tests++; if (stalls !== 0 || rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lru_keep got %0d/%h exp 0/deadbeef", stalls, rd); end
        access(1'b0, 10'h025, 32'h0, LINE_B, 1, 2);
        tests++; if (stalls !== 4 || rd !== 32'hB0B0_0002) begin errors++; $display("FAIL lru_refetch got %0d/%h exp 4/b0b00002", stalls, rd); end
    endtask

    task automatic test_dirty_evict;
        access(1'b0, 10'h064, 32'h0, LINE_D, 2, 3);
        tests++; if (stalls !== 7) begin errors++; $display("FAIL wb_stall got %0d exp 7", stalls); end
        tests++; if (n_wb !== 1 || n_rf !== 1) begin errors++; $display("FAIL wb_txn got wb=%0d rf=%0d exp 1/1", n_wb, n_rf); end
        tests++; if (wb_addr !== 7'h01) begin errors++; $display("FAIL wb_addr got %h exp 01", wb_addr); end
        tests++; if (wb_data[63:0] !== 64'hA5A5_0002_DEAD_BEEF) begin errors++; $display("FAIL wb_data got %h exp a5a50002deadbeef", wb_data[63:0]); end
        tests++; if (rf_addr !== 7'h19 || rd !== 32'hD0D0_0001) begin errors++; $display("FAIL wb_refill got %h/%h exp 19/d0d00001", rf_addr, rd); end
    endtask

    task automatic test_back_to_back;
        access(1'b1, 10'h108, 32'h1234_5678, LINE_E, 1, 1);
        tests++; if (stalls !== 3 || hm !== 1'b1) begin errors++; $display("FAIL store_miss got %0d/%b exp 3/1", stalls, hm); end
        access(1'b0, 10'h108, 32'h0, LINE_E, 1, 1);
        tests++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL store_merge got %h exp 12345678", rd); end
        access(1'b0, 10'h109, 32'h0, LINE_E, 1, 1);
        tests++; if (rd !== 32'hE0E0_0002) begin errors++; $display("FAIL merge_neighbor got %h exp e0e00002", rd); end
    endtask

    task automatic test_idle_ready;
        @(negedge clk);
        mem_rdata = '1;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        tests++; if (mem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL idle_ready got req=%b stall=%b exp 0/0", mem_req, stall); end
        access(1'b0, 10'h109, 32'h0, LINE_E, 1, 1);
        tests++; if (stalls !== 0 || rd !== 32'hE0E0_0002) begin errors++; $display("FAIL idle_ready_data got %0d/%h exp 0/e0e00002", stalls, rd); end
    endtask

    task automatic test_reset_refill;
        bit seen;
        seen = 0;
        @(negedge clk);
        mem_read = 1'b1;
        addr = 10'h0AC;
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            if (mem_req) seen = 1;
            else @(negedge clk);
        end
        tests++; if (!seen) begin errors++; $display("FAIL rr_req got 0 exp 1"); end
        @(negedge clk);
        rstn = 1'b0;
        mem_read = 1'b0;
        @(negedge clk);
        #1;
        tests++; if (mem_req !== 1'b0 || stall !== 1'b0 || hit_miss !== 1'b0) begin errors++; $display("FAIL rr_abort got req=%b stall=%b hit=%b exp 0/0/0", mem_req, stall, hit_miss); end
        rstn = 1'b1;
        access(1'b0, 10'h0AC, 32'h0, LINE_F, 1, 2);
        tests++; if (stalls !== 4 || rd !== 32'hF0F0_0001) begin errors++; $display("FAIL rr_remiss got %0d/%h exp 4/f0f00001", stalls, rd); end
        access(1'b0, 10'h004, 32'h0, LINE_A, 1, 1);
        tests++; if (stalls !== 3 || n_wb !== 0) begin errors++; $display("FAIL rr_cleared got %0d/%0d exp 3/0", stalls, n_wb); end
    endtask

`ifdef CACHE_STATS_EN
    task automatic test_stats;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        tests++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin errors++; $display("FAIL stats_reset got %0d/%0d exp 0/0", hit_count, miss_count); end
        access(1'b0, 10'h000, 32'h0, LINE_A, 1, 1);
        access(1'b0, 10'h004, 32'h0, LINE_B, 1, 1);
        access(1'b0, 10'h008, 32'h0, LINE_C, 1, 1);
        access(1'b0, 10'h000, 32'h0, LINE_A, 1, 1);
        access(1'b0, 10'h001, 32'h0, LINE_A, 1, 1);
        access(1'b0, 10'h004, 32'h0, LINE_B, 1, 1);
        access(1'b0, 10'h005, 32'h0, LINE_B, 1, 1);
        access(1'b0, 10'h008, 32'h0, LINE_C, 1, 1);
        #1;
        tests++; if (miss_count !== 16'd3) begin errors++; $display("FAIL stats_miss got %0d exp 3", miss_count); end
        tests++; if (hit_count !== 16'd5) begin errors++; $display("FAIL stats_hit got %0d exp 5", hit_count); end
        @(negedge clk);
        mem_read = 1'b1;
        addr = 10'h000;
        repeat (65540) @(negedge clk);
        mem_read = 1'b0;
        #1;
        tests++; if (hit_count !== 16'hFFFF) begin errors++; $display("FAIL stats_sat got %h exp ffff", hit_count); end
    endtask
`endif

    initial begin
        test_reset;
        test_cold_load;
        test_store_hit;
        test_lru;
        test_dirty_evict;
        test_back_to_back;
        test_idle_ready;
        test_reset_refill;
`ifdef CACHE_STATS_EN
        test_stats;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
